// File: rtl/clk_div_ctrl.sv
// Run/stop and ratio controller for a counter-based clock divider.
// Ratio changes and stops are deferred to a period boundary so div_out never shows a runt period.
module clk_div_ctrl #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             div_out,
  output logic             div_tick,
  output logic [CNT_W-1:0] active_div,
  output logic             running
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] active_q, active_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pend_valid_q, pend_valid_d;
  logic             cfg_ready_q, cfg_err_q, div_out_q, div_tick_q, running_q;
  logic             cfg_err_d, div_out_d, div_tick_d, running_d;
  logic             accept, legal, wrap;

  // Next-state logic: counting, handshake and deferred ratio application.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    active_d     = active_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;

    accept    = cfg_valid && cfg_ready_q;
    legal     = (cfg_div > ONE);
    cfg_err_d = accept && !legal;
    // >= keeps the counter bounded even if it were ever corrupted past the wrap.
    wrap      = (cnt_q >= (active_q - ONE));

    case (state_q)
      IDLE: begin
        cnt_d    = ZERO;
        active_d = (accept && legal) ? cfg_div : active_q;
        state_d  = en ? RUN : IDLE;
      end
      RUN, STOPPING: begin
        if (wrap) begin
          cnt_d        = ZERO;
          pend_valid_d = 1'b0;
          if (accept && legal) begin
            active_d = cfg_div;
          end else if (pend_valid_q) begin
            active_d = pend_q;
          end else begin
            active_d = active_q;
          end
          state_d = en ? RUN : IDLE;
        end else begin
          cnt_d = cnt_q + ONE;
          if (accept && legal) begin
            pend_d       = cfg_div;
            pend_valid_d = 1'b1;
          end else begin
            pend_d       = pend_q;
            pend_valid_d = pend_valid_q;
          end
          state_d = en ? RUN : STOPPING;
        end
      end
      default: begin
        state_d      = IDLE;
        cnt_d        = ZERO;
        pend_valid_d = 1'b0;
      end
    endcase

    running_d  = (state_d != IDLE);
    div_out_d  = running_d && (cnt_d < (active_d >> 1));
    div_tick_d = running_d && (cnt_d == ZERO);
  end

  // State and registered outputs; rst aborts any period and drops the pending ratio.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= ZERO;
      active_q     <= CNT_W'(DEFAULT_DIV);
      pend_q       <= ZERO;
      pend_valid_q <= 1'b0;
      cfg_ready_q  <= 1'b1;
      cfg_err_q    <= 1'b0;
      div_out_q    <= 1'b0;
      div_tick_q   <= 1'b0;
      running_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      active_q     <= active_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      cfg_ready_q  <= !pend_valid_d;
      cfg_err_q    <= cfg_err_d;
      div_out_q    <= div_out_d;
      div_tick_q   <= div_tick_d;
      running_q    <= running_d;
    end
  end

  assign cfg_ready  = cfg_ready_q;
  assign cfg_err    = cfg_err_q;
  assign div_out    = div_out_q;
  assign div_tick   = div_tick_q;
  assign active_div = active_q;
  assign running    = running_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: directed steps push expected outputs, a negedge monitor compares.
module tb_clk_div_ctrl;

  logic       clk = 1'b0;
  logic       rst, en, cfg_valid;
  logic [7:0] cfg_div;
  logic       cfg_ready, cfg_err, div_out, div_tick, running;
  logic [7:0] active_div;

  typedef struct packed {
    logic       o;
    logic       t;
    logic       r;
    logic       e;
    logic       u;
    logic [7:0] a;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   sid    = 0;

  clk_div_ctrl #(.CNT_W(8), .DEFAULT_DIV(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .div_out   (div_out),
    .div_tick  (div_tick),
    .active_div(active_div),
    .running   (running)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs; push the outputs expected right after the sampling edge.
  task automatic step(input logic r, input logic e, input logic v, input logic [7:0] d,
                      input logic eo, input logic et, input logic [7:0] ea,
                      input logic er, input logic ee, input logic eu);
    exp_t x;
    rst = r; en = e; cfg_valid = v; cfg_div = d;
    @(posedge clk);
    x.o = eo; x.t = et; x.r = er; x.e = ee; x.u = eu; x.a = ea;
    exp_q.push_back(x);
    #1;
  endtask

  // One full undisturbed running period of ratio n.
  task automatic period(input int n);
    for (int k = 0; k < n; k++)
      step(1'b0, 1'b1, 1'b0, 8'd0, (k < n / 2), (k == 0), 8'(n), 1'b1, 1'b0, 1'b1);
  endtask

  // Monitor: compare every presented output against the oldest expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t x, act;
      x = exp_q.pop_front();
      act = {div_out, div_tick, cfg_ready, cfg_err, running, active_div};
      checks++;
      if (act !== x) begin
        errors++;
        $display("FAIL step%0d out/tick/ready/err/run/active got %b%b%b%b%b/%0d expected %b%b%b%b%b/%0d",
                 sid, act.o, act.t, act.r, act.e, act.u, act.a, x.o, x.t, x.r, x.e, x.u, x.a);
      end
      sid++;
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = 8'd0;
    // Reset values
    step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd4, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd4, 1'b1, 1'b0, 1'b0);
    // Default ratio 4: 1100 periods
    period(4);
    period(4);
    // Ratio 7 offered on the wrap cycle bypasses pend
    step(1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 8'd4, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 8'd4, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd4, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd4, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 8'd7, 1'b1, 1'b1, 8'd7, 1'b1, 1'b0, 1'b1);
    for (int k = 1; k < 7; k++)
      step(1'b0, 1'b1, 1'b0, 8'd0, (k < 3), 1'b0, 8'd7, 1'b1, 1'b0, 1'b1);
    // Back to 4 on the wrap, then offer 5 at cnt=1 (pended until the wrap)
    step(1'b0, 1'b1, 1'b1, 8'd4, 1'b1, 1'b1, 8'd4, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 8'd4, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 8'd5, 1'b0, 1'b0, 8'd4, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 8'd9, 1'b0, 1'b0, 8'd4, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 8'd5, 1'b1, 1'b0, 1'b1);
    // Illegal ratios 1 and 0 inside the 5-period: one err pulse each
    step(1'b0, 1'b1, 1'b1, 8'd1, 1'b1, 1'b0, 8'd5, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd5, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 8'd5, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd5, 1'b1, 1'b0, 1'b1);
    period(5);
    // Ratio 6 on the wrap; drop en at cnt=2 and stop at the period end
    step(1'b0, 1'b1, 1'b1, 8'd6, 1'b1, 1'b1, 8'd6, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 8'd6, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 8'd6, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd6, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd6, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd6, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd6, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd6, 1'b1, 1'b0, 1'b0);
    // Restart; drop en at cnt=2, re-assert at cnt=4: no interruption
    step(1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 8'd6, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 8'd6, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 8'd6, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd6, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd6, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd6, 1'b1, 1'b0, 1'b1);
    period(6);
    // Ratio 8 on the wrap, pend 3, then reset at cnt=3
    step(1'b0, 1'b1, 1'b1, 8'd8, 1'b1, 1'b1, 8'd8, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 8'd3, 1'b1, 1'b0, 8'd8, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 8'd8, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 8'd8, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd4, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd4, 1'b1, 1'b0, 1'b0);
    period(4);
    period(4);
    // en dropped on the wrap cycle goes straight to IDLE
    step(1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 8'd4, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 8'd4, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd4, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd4, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd4, 1'b1, 1'b0, 1'b0);

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
